// File: rtl/cordic_pkg.sv
// ============================================================================
// Module      : cordic_pkg
// Description : Shared CORDIC constants, angle-correction encoding and
//               fixed-point rounding/saturation helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cordic_pkg;

    typedef enum logic [1:0] {
        ZC_NONE   = 2'b00,
        ZC_ADD_PI = 2'b01,
        ZC_SUB_PI = 2'b10
    } zcorr_t;

    // round(0.6072529350 * 2^kfrac), evaluated in integer arithmetic
    function automatic int k_inv(input int kfrac);
        longint num;
        num = 64'sd6072529350 <<< kfrac;
        return int'((num + 64'sd5000000000) / 64'sd10000000000);
    endfunction

    function automatic int pi_fxp(input int frac_bits);
        longint num;
        num = 64'sd31415926536 <<< frac_bits;
        return int'((num + 64'sd5000000000) / 64'sd10000000000);
    endfunction

    function automatic logic signed [63:0] sat_s(input logic signed [63:0] v,
                                                  input int                  w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        return v;
    endfunction

    // Round-half-up followed by an arithmetic right shift
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] v,
                                                        input int                  sh);
        return (v + (64'sd1 <<< (sh - 1))) >>> sh;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cordic_post_if.sv
// ============================================================================
// Module      : cordic_post_if
// Description : Data/valid bundle between the last CORDIC step, the
//               post-processing stage and the downstream consumer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cordic_post_if #(
    parameter int WORD_WIDTH = 20
);
    logic signed [WORD_WIDTH-1:0] x_i;
    logic signed [WORD_WIDTH-1:0] y_i;
    logic signed [WORD_WIDTH-1:0] z_i;
    logic                         vld_i;
    logic                         neg_i;
    logic [1:0]                   zcorr_i;

    logic signed [WORD_WIDTH-1:0] x_o;
    logic signed [WORD_WIDTH-1:0] y_o;
    logic signed [WORD_WIDTH-1:0] z_o;
    logic                         vld_o;
    logic                         ovf_o;

    modport master (
        output x_i, y_i, z_i, vld_i, neg_i, zcorr_i,
        input  x_o, y_o, z_o, vld_o, ovf_o
    );

    modport slave (
        input  x_i, y_i, z_i, vld_i, neg_i, zcorr_i,
        output x_o, y_o, z_o, vld_o, ovf_o
    );
endinterface

`default_nettype wire

// File: rtl/cordic_gain_mul.sv
// ============================================================================
// Module      : cordic_gain_mul
// Description : Registered signed multiply by a constant coefficient.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_gain_mul #(
    parameter int IN_W  = 20,
    parameter int C_W   = 18,
    parameter int OUT_W = 38,
    parameter int COEF  = 79594
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic signed [IN_W-1:0]  i_a,
    output      logic signed [OUT_W-1:0] o_p
);
    localparam logic signed [C_W-1:0] c_COEF = C_W'(COEF);

    always_ff @(posedge clk) begin
        if (rst)
            o_p <= '0;
        else
            o_p <= OUT_W'(i_a) * OUT_W'(c_COEF);
    end
endmodule

`default_nettype wire

// File: rtl/cordic_post.sv
// ============================================================================
// Module      : cordic_post
// Description : CORDIC output stage: 1/K gain removal, quadrant undo and
//               saturation. Gain removal built only with CORDIC_POST_GAIN_COMP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_post
    import cordic_pkg::*;
#(
    parameter int WORD_WIDTH = 20,
    parameter int FRAC_BITS  = 16,
    parameter int K_FRAC     = 17
) (
    input  wire logic         clk,
    input  wire logic         rst,
    cordic_post_if.slave      bus
);
    localparam int PW = WORD_WIDTH + K_FRAC + 1;
    localparam int ZW = WORD_WIDTH + 1;
    localparam logic signed [ZW-1:0] c_PI = ZW'(pi_fxp(FRAC_BITS));

    logic signed [PW-1:0] w_px;
    logic signed [PW-1:0] w_py;
    logic signed [ZW-1:0] w_zs;
    logic signed [ZW-1:0] r_zs;
    logic                 r_neg;
    logic                 r_vld1;

`ifdef CORDIC_POST_GAIN_COMP_EN
    cordic_gain_mul #(
        .IN_W (WORD_WIDTH),
        .C_W  (K_FRAC + 1),
        .OUT_W(PW),
        .COEF (k_inv(K_FRAC))
    ) u_mul_x (
        .clk(clk), .rst(rst), .i_a(bus.x_i), .o_p(w_px)
    );

    cordic_gain_mul #(
        .IN_W (WORD_WIDTH),
        .C_W  (K_FRAC + 1),
        .OUT_W(PW),
        .COEF (k_inv(K_FRAC))
    ) u_mul_y (
        .clk(clk), .rst(rst), .i_a(bus.y_i), .o_p(w_py)
    );
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            w_px <= '0;
            w_py <= '0;
        end else begin
            w_px <= PW'(bus.x_i);
            w_py <= PW'(bus.y_i);
        end
    end
`endif

    // Code 2'b11 falls through to "no correction"
    always_comb begin
        w_zs = ZW'(bus.z_i);
        case (bus.zcorr_i)
            ZC_ADD_PI: w_zs = ZW'(bus.z_i) + c_PI;
            ZC_SUB_PI: w_zs = ZW'(bus.z_i) - c_PI;
            default:   w_zs = ZW'(bus.z_i);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_zs   <= '0;
            r_neg  <= 1'b0;
            r_vld1 <= 1'b0;
        end else begin
            r_zs   <= w_zs;
            r_neg  <= bus.neg_i;
            r_vld1 <= bus.vld_i;
        end
    end

    logic signed [63:0] w_rx, w_ry, w_nx, w_ny, w_zx;
    logic signed [63:0] w_sx, w_sy, w_sz;

    always_comb begin
`ifdef CORDIC_POST_GAIN_COMP_EN
        w_rx = round_shift(64'(w_px), K_FRAC);
        w_ry = round_shift(64'(w_py), K_FRAC);
`else
        w_rx = 64'(w_px);
        w_ry = 64'(w_py);
`endif
        // Negation happens at full width so that -MIN is caught by saturation
        w_nx = r_neg ? -w_rx : w_rx;
        w_ny = r_neg ? -w_ry : w_ry;
        w_zx = 64'(r_zs);
        w_sx = sat_s(w_nx, WORD_WIDTH);
        w_sy = sat_s(w_ny, WORD_WIDTH);
        w_sz = sat_s(w_zx, WORD_WIDTH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.x_o   <= '0;
            bus.y_o   <= '0;
            bus.z_o   <= '0;
            bus.vld_o <= 1'b0;
            bus.ovf_o <= 1'b0;
        end else begin
            bus.x_o   <= w_sx[WORD_WIDTH-1:0];
            bus.y_o   <= w_sy[WORD_WIDTH-1:0];
            bus.z_o   <= w_sz[WORD_WIDTH-1:0];
            bus.vld_o <= r_vld1;
            bus.ovf_o <= (w_sx != w_nx) || (w_sy != w_ny) || (w_sz != w_zx);
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_cordic_post.sv
// ============================================================================
// Module      : tb_cordic_post
// Description : Directed self-checking bench for cordic_post; expectations
//               follow CORDIC_POST_GAIN_COMP_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cordic_post;
    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    cordic_post_if #(.WORD_WIDTH(20)) bus ();

    cordic_post #(
        .WORD_WIDTH(20),
        .FRAC_BITS (16),
        .K_FRAC    (17)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef CORDIC_POST_GAIN_COMP_EN
    localparam int c_ONE    = 39797;
    localparam int c_TWO    = 79594;
    localparam int c_MINNEG = 318376;
    localparam int c_MINOVF = 0;
`else
    localparam int c_ONE    = 65536;
    localparam int c_TWO    = 131072;
    localparam int c_MINNEG = 524287;
    localparam int c_MINOVF = 1;
`endif

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int x, input int y, input int z,
                         input logic neg, input logic [1:0] zc, input logic vld);
        bus.x_i     = 20'(x);
        bus.y_i     = 20'(y);
        bus.z_i     = 20'(z);
        bus.neg_i   = neg;
        bus.zcorr_i = zc;
        bus.vld_i   = vld;
    endtask

    task automatic chk_out(input string tag, input int x, input int y,
                           input int z, input logic ovf);
        chk({tag, ".vld"}, 32'(bus.vld_o), 32'sd1);
        chk({tag, ".x"},   32'(bus.x_o),   x);
        chk({tag, ".y"},   32'(bus.y_o),   y);
        chk({tag, ".z"},   32'(bus.z_o),   z);
        chk({tag, ".ovf"}, 32'(bus.ovf_o), 32'(ovf));
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive(0, 0, 0, 1'b0, 2'b00, 1'b0);
        repeat (3) tick();

        chk("rst.vld", 32'(bus.vld_o), 0);
        chk("rst.ovf", 32'(bus.ovf_o), 0);
        chk("rst.x",   32'(bus.x_o),   0);
        chk("rst.y",   32'(bus.y_o),   0);
        chk("rst.z",   32'(bus.z_o),   0);

        rst = 1'b0;
        tick();

        // Basic gain removal with a single-cycle valid
        drive(65536, 0, 0, 1'b0, 2'b00, 1'b1);
        tick();
        drive(0, 0, 0, 1'b0, 2'b00, 1'b0);
        chk("t1.lat1", 32'(bus.vld_o), 0);
        tick();
        chk_out("t1", c_ONE, 0, 0, 1'b0);
        tick();
        chk("t1.pulse", 32'(bus.vld_o), 0);

        // Negation plus +pi correction
        drive(65536, -65536, -100000, 1'b1, 2'b01, 1'b1);
        tick();
        drive(0, 0, 0, 1'b0, 2'b00, 1'b0);
        tick();
        chk_out("t2", -c_ONE, c_ONE, 105887, 1'b0);

        // Angle saturation at both rails, plus the unused 2'b11 code
        drive(0, 0, 400000, 1'b0, 2'b01, 1'b1);
        tick();
        drive(0, 0, -400000, 1'b0, 2'b10, 1'b1);
        tick();
        chk_out("t3a", 0, 0, 524287, 1'b1);
        drive(0, 0, 1234, 1'b0, 2'b11, 1'b1);
        tick();
        chk_out("t3b", 0, 0, -524288, 1'b1);
        drive(0, 0, 0, 1'b0, 2'b00, 1'b0);
        tick();
        chk_out("t3c", 0, 0, 1234, 1'b0);

        // Negating the most negative input
        drive(-524288, 0, 0, 1'b1, 2'b00, 1'b1);
        tick();
        drive(0, 0, 0, 1'b0, 2'b00, 1'b0);
        tick();
        chk_out("t4", c_MINNEG, 0, 0, c_MINOVF);

        // Back-to-back samples
        drive(65536, 0, 0, 1'b0, 2'b00, 1'b1);
        tick();
        drive(131072, 0, 0, 1'b0, 2'b00, 1'b1);
        tick();
        chk_out("t5a", c_ONE, 0, 0, 1'b0);
        drive(-65536, 0, 0, 1'b0, 2'b00, 1'b1);
        tick();
        chk_out("t5b", c_TWO, 0, 0, 1'b0);
        drive(0, 0, 0, 1'b0, 2'b00, 1'b0);
        tick();
        chk_out("t5c", -c_ONE, 0, 0, 1'b0);
        tick();
        chk("t5.end", 32'(bus.vld_o), 0);

        // Reset mid-flight discards the sample
        drive(65536, 65536, 1000, 1'b0, 2'b00, 1'b1);
        tick();
        drive(0, 0, 0, 1'b0, 2'b00, 1'b0);
        rst = 1'b1;
        tick();
        chk("t6.vld0", 32'(bus.vld_o), 0);
        chk("t6.x0",   32'(bus.x_o),   0);
        chk("t6.y0",   32'(bus.y_o),   0);
        chk("t6.z0",   32'(bus.z_o),   0);
        chk("t6.ovf0", 32'(bus.ovf_o), 0);
        tick();
        chk("t6.vld1", 32'(bus.vld_o), 0);

        // Valid presented together with reset is dropped
        drive(65536, 0, 0, 1'b0, 2'b00, 1'b1);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 1'b0, 2'b00, 1'b0);
        tick();
        chk("t6.drop1", 32'(bus.vld_o), 0);
        tick();
        chk("t6.drop2", 32'(bus.vld_o), 0);

        // First sample after release arrives exactly two cycles later
        drive(131072, 0, 0, 1'b0, 2'b00, 1'b1);
        tick();
        drive(0, 0, 0, 1'b0, 2'b00, 1'b0);
        chk("t6.lat1", 32'(bus.vld_o), 0);
        tick();
        chk_out("t6.new", c_TWO, 0, 0, 1'b0);
        tick();
        chk("t6.end", 32'(bus.vld_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
